zero_trunc_adder: RTL and testbench
===================================

ZERO_TRUNC_ADDER -- requirements
Module: zero_trunc_adder

Interface
REQ-001 SHALL have parameter N, default 4: total operand bit-width (N >= 1).
REQ-002 SHALL have parameter K, default 2: number of low-order approximate (truncated) bit positions, 0 <= K <= N.
REQ-003 SHALL have parameter CNT_W, default 16: error-counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port i_Clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port i_Rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port i_A  input  N  operand A, unsigned.
REQ-008 SHALL have port i_B  input  N  operand B, unsigned.
REQ-009 SHALL have port i_Valid  input  1  operands valid this cycle.
REQ-010 SHALL have port o_Sum  output  N  registered approximate sum.
REQ-011 SHALL have port o_Cout  output  1  registered approximate carry-out.
REQ-012 SHALL have port o_Valid  output  1  o_Sum/o_Cout hold a new result.
REQ-013 SHALL have port o_ErrCnt  output  CNT_W  number of accepted operand pairs whose approximate result differed from exact.
REQ-014 SHALL have port o_ErrMax  output  N+1  largest |exact - approximate| seen since reset.

Function
REQ-015 SHALL have no carry-in port; carry into bit 0 is constant 0.
REQ-016 SHALL force approximate sum bits [K-1:0] to 0 and carry into bit K to 0, regardless of operands.
REQ-017 SHALL compute sum bits [N-1:K] and carry-out as the exact ripple-carry sum of i_A[N-1:K] + i_B[N-1:K].
REQ-018 SHALL reduce to an exact N-bit adder when K = 0, and SHALL give o_Sum = 0, o_Cout = 0 when K = N.
REQ-019 SHALL register {o_Cout,o_Sum} one cycle after i_Valid=1 (latency 1), with o_Valid=1 in that cycle only; outputs hold when i_Valid=0.
REQ-020 SHALL compute exact reference {c,s} = i_A + i_B (N+1 bits) internally; error magnitude = exact - approximate, never negative, equal to i_A[K-1:0] + i_B[K-1:0].
REQ-021 SHALL, on each accepted pair with nonzero error, increment o_ErrCnt, saturating at all-ones.
REQ-022 SHALL update o_ErrMax to the error magnitude when it exceeds the current value; update is registered, same cycle as o_Valid.
REQ-023 SHALL accept back-to-back operands every cycle without stall.

Reset
REQ-024 SHALL on i_Rst=1 clear o_Sum, o_Cout, o_Valid, o_ErrCnt, o_ErrMax to 0 at the next rising edge; i_Valid ignored in that cycle.
REQ-025 SHALL discard any operand pair presented in the reset cycle; reset takes priority over accept.

Structure
REQ-026 SHALL place default N, K, CNT_W constants in a shared package zero_trunc_adder_pkg.
REQ-027 SHALL build the exact upper section from N-K instances of one sub-module full_adder_1b (a, b, cin -> sum, cout); approximate cells are constant-0 sum/carry outputs.
REQ-028 SHALL use generate loops over bit index so N and K are fully parameterized.

Verification (N=4, K=2)
REQ-029 SHALL check A=0101, B=0011 -> next cycle o_Cout=0, o_Sum=0100, o_Valid=1, o_ErrCnt=1, o_ErrMax=4.
REQ-030 SHALL check A=1111, B=1111 -> o_Cout=1, o_Sum=1000, error 6, o_ErrMax=6.
REQ-031 SHALL check A=1100, B=0100 -> o_Cout=1, o_Sum=0000, no error, o_ErrCnt unchanged.
REQ-032 SHALL check exhaustive sweep of all 256 pairs from reset -> o_ErrCnt=240, o_ErrMax=6.
REQ-033 SHALL check reset asserted with i_Valid=1 mid-stream -> all outputs 0 next cycle, o_Valid=0.
REQ-034 SHALL check CNT_W=2, four erroneous pairs -> o_ErrCnt saturates at 3.

Source files
------------

// File: rtl/zero_trunc_adder_pkg.sv
// Shared default sizing for the zero-truncation approximate adder.
package zero_trunc_adder_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned K_DEF     = 2;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/zero_trunc_adder_fa.sv
// One-bit full adder cell used for the exact upper section of the adder.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/zero_trunc_adder.sv
// Approximate adder: low K bits forced to zero with no carry into bit K, exact ripple above;
// tracks how often and by how much the result differs from the exact sum.
module zero_trunc_adder
  import zero_trunc_adder_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned K     = K_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [N-1:0]     i_A,
  input  logic [N-1:0]     i_B,
  input  logic             i_Valid,
  output logic [N-1:0]     o_Sum,
  output logic             o_Cout,
  output logic             o_Valid,
  output logic [CNT_W-1:0] o_ErrCnt,
  output logic [N:0]       o_ErrMax
);

  logic [N:K]       carry;
  logic [N-1:0]     approx_sum;
  logic [N:0]       exact;
  logic [N:0]       err_mag;

  logic [N-1:0]     sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             valid_q,  valid_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic [N:0]       errmax_q, errmax_d;

  assign carry[K] = 1'b0;

  for (genvar i = 0; i < int'(N); i++) begin : g_bit
    if (i < int'(K)) begin : g_apx
      assign approx_sum[i] = 1'b0;
    end else begin : g_exact
      full_adder_1b u_fa (
        .a    (i_A[i]),
        .b    (i_B[i]),
        .cin  (carry[i]),
        .sum  (approx_sum[i]),
        .cout (carry[i+1])
      );
    end
  end

  // Truncation only drops value, so exact minus approximate is never negative.
  assign exact   = {1'b0, i_A} + {1'b0, i_B};
  assign err_mag = exact - {carry[N], approx_sum};

  always_comb begin
    sum_d    = sum_q;
    cout_d   = cout_q;
    valid_d  = 1'b0;
    errcnt_d = errcnt_q;
    errmax_d = errmax_q;
    if (i_Valid) begin
      sum_d   = approx_sum;
      cout_d  = carry[N];
      valid_d = 1'b1;
      if ((err_mag != '0) && (errcnt_q != '1)) begin
        errcnt_d = errcnt_q + CNT_W'(1);
      end
      if (err_mag > errmax_q) begin
        errmax_d = err_mag;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sum_q    <= '0;
      cout_q   <= 1'b0;
      valid_q  <= 1'b0;
      errcnt_q <= '0;
      errmax_q <= '0;
    end else begin
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      valid_q  <= valid_d;
      errcnt_q <= errcnt_d;
      errmax_q <= errmax_d;
    end
  end

  assign o_Sum    = sum_q;
  assign o_Cout   = cout_q;
  assign o_Valid  = valid_q;
  assign o_ErrCnt = errcnt_q;
  assign o_ErrMax = errmax_q;

endmodule

// File: tb/tb_zero_trunc_adder.sv
// Self-checking bench for zero_trunc_adder (N=4, K=2) with a 16-bit and a 2-bit error counter.
module tb_zero_trunc_adder;

  localparam int unsigned N = 4;
  localparam int unsigned K = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a, b;
  logic         vin;

  logic [N-1:0] sum_w, ssum_w;
  logic         cout_w, scout_w, vout_w, svout_w;
  logic [15:0]  cnt_w;
  logic [1:0]   scnt_w;
  logic [N:0]   max_w, smax_w;

  int checks = 0;
  int errors = 0;

  // Reference state, derived from plain arithmetic on the operands.
  int m_sum, m_cout, m_valid, m_cnt, m_scnt, m_max;

  always #5 clk = ~clk;

  zero_trunc_adder #(.N(N), .K(K), .CNT_W(16)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_A(a), .i_B(b), .i_Valid(vin),
    .o_Sum(sum_w), .o_Cout(cout_w), .o_Valid(vout_w),
    .o_ErrCnt(cnt_w), .o_ErrMax(max_w)
  );

  zero_trunc_adder #(.N(N), .K(K), .CNT_W(2)) dut_sat (
    .i_Clk(clk), .i_Rst(rst), .i_A(a), .i_B(b), .i_Valid(vin),
    .o_Sum(ssum_w), .o_Cout(scout_w), .o_Valid(svout_w),
    .o_ErrCnt(scnt_w), .o_ErrMax(smax_w)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int ai, input int bi, input int v, input int r);
    int exact, approx, err;
    if (r != 0) begin
      m_sum = 0; m_cout = 0; m_valid = 0; m_cnt = 0; m_scnt = 0; m_max = 0;
    end else begin
      m_valid = v;
      if (v != 0) begin
        exact  = ai + bi;
        approx = ((ai >> K) + (bi >> K)) << K;
        err    = exact - approx;
        m_sum  = approx % (1 << N);
        m_cout = approx >> N;
        if (err != 0) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_scnt < 3) m_scnt++;
        end
        if (err > m_max) m_max = err;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".sum"},   int'(sum_w),   m_sum);
    chk({tag, ".cout"},  int'(cout_w),  m_cout);
    chk({tag, ".valid"}, int'(vout_w),  m_valid);
    chk({tag, ".cnt"},   int'(cnt_w),   m_cnt);
    chk({tag, ".max"},   int'(max_w),   m_max);
    chk({tag, ".scnt"},  int'(scnt_w),  m_scnt);
    chk({tag, ".ssum"},  int'(ssum_w),  m_sum);
    chk({tag, ".smax"},  int'(smax_w),  m_max);
  endtask

  // Apply one cycle of inputs, advance the model, and sample #1 after the edge.
  task automatic step(input int ai, input int bi, input int v, input int r);
    a   = N'(ai);
    b   = N'(bi);
    vin = v[0];
    rst = r[0];
    @(posedge clk);
    model_step(ai, bi, v, r);
    #1;
  endtask

  typedef struct {
    int a, b, v;
    int e_sum, e_cout, e_valid, e_cnt, e_max, e_scnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    rst = 1'b1; vin = 1'b0; a = '0; b = '0;
    m_sum = 0; m_cout = 0; m_valid = 0; m_cnt = 0; m_scnt = 0; m_max = 0;

    vecs[0] = '{4'b0101, 4'b0011, 1, 4'b0100, 0, 1, 1, 4, 1};
    vecs[1] = '{4'b1111, 4'b1111, 1, 4'b1000, 1, 1, 2, 6, 2};
    vecs[2] = '{4'b1100, 4'b0100, 1, 4'b0000, 1, 1, 2, 6, 2};
    vecs[3] = '{4'b1111, 4'b0001, 0, 4'b0000, 1, 0, 2, 6, 2};
    vecs[4] = '{4'b0010, 4'b0001, 1, 4'b0000, 0, 1, 3, 6, 3};

    // Reset state
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    chk("rst.sum", int'(sum_w), 0);
    chk("rst.cout", int'(cout_w), 0);
    chk("rst.valid", int'(vout_w), 0);
    chk("rst.cnt", int'(cnt_w), 0);
    chk("rst.max", int'(max_w), 0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].a, vecs[i].b, vecs[i].v, 0);
      chk($sformatf("vec%0d.sum", i),   int'(sum_w),  vecs[i].e_sum);
      chk($sformatf("vec%0d.cout", i),  int'(cout_w), vecs[i].e_cout);
      chk($sformatf("vec%0d.valid", i), int'(vout_w), vecs[i].e_valid);
      chk($sformatf("vec%0d.cnt", i),   int'(cnt_w),  vecs[i].e_cnt);
      chk($sformatf("vec%0d.max", i),   int'(max_w),  vecs[i].e_max);
      chk($sformatf("vec%0d.scnt", i),  int'(scnt_w), vecs[i].e_scnt);
    end

    // Reset with a valid pair mid-stream: pair discarded, everything cleared
    step(4'b0111, 4'b0011, 1, 0);
    step(4'b1111, 4'b1111, 1, 1);
    chk("midrst.sum", int'(sum_w), 0);
    chk("midrst.cout", int'(cout_w), 0);
    chk("midrst.valid", int'(vout_w), 0);
    chk("midrst.cnt", int'(cnt_w), 0);
    chk("midrst.max", int'(max_w), 0);
    step(4'b0001, 4'b0001, 1, 0);
    chk("postrst.sum", int'(sum_w), 0);
    chk("postrst.valid", int'(vout_w), 1);
    chk("postrst.cnt", int'(cnt_w), 1);
    chk("postrst.max", int'(max_w), 2);

    // Saturation of the 2-bit counter
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
    chk("sat.scnt", int'(scnt_w), 3);
    chk("sat.cnt", int'(cnt_w), 4);
    chk("sat.max", int'(max_w), 1);

    // Exhaustive back-to-back sweep from reset
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        step(i, j, 1, 0);
        check_model($sformatf("sweep%0d_%0d", i, j));
      end
    end
    chk("sweep.cnt", int'(cnt_w), 240);
    chk("sweep.max", int'(max_w), 6);
    chk("sweep.scnt", int'(scnt_w), 3);

    // Randomized traffic with gaps and occasional reset
    step(0, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      step(int'($urandom_range(15)), int'($urandom_range(15)),
           int'($urandom_range(3) != 0), int'($urandom_range(40) == 0));
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
